// File: rtl/eth_rx_frame_buffer.sv
// Store-and-forward RX frame buffer: accepts every MAC beat, drops bad/overflowing frames,
// forwards only committed good frames. Define ETH_RX_STATS_EN to build the frame counters.
module eth_rx_frame_buffer #(
    parameter int DEPTH_LOG2 = 9
) (
    input  logic        clock,
    input  logic        resetn,
    input  logic [63:0] s_axis_tdata,
    input  logic [7:0]  s_axis_tkeep,
    input  logic        s_axis_tlast,
    input  logic        s_axis_tuser,
    input  logic        s_axis_tvalid,
    output logic [63:0] m_axis_tdata,
    output logic [7:0]  m_axis_tkeep,
    output logic        m_axis_tlast,
    output logic        m_axis_tuser,
    output logic        m_axis_tvalid,
    input  logic        m_axis_tready,
    output logic [15:0] frames_ok,
    output logic [15:0] frames_bad,
    output logic [15:0] frames_ovf
);

    localparam int AW    = DEPTH_LOG2;
    localparam int PW    = DEPTH_LOG2 + 1;
    localparam int DEPTH = 1 << DEPTH_LOG2;

    typedef enum logic [1:0] {ST_IDLE, ST_WRITE, ST_DROP} wr_state_e;
    typedef enum logic [1:0] {EV_NONE, EV_OK, EV_BAD, EV_OVF} frame_ev_e;

    typedef struct packed {
        logic        last;
        logic [7:0]  keep;
        logic [63:0] data;
    } beat_t;

    beat_t     mem [DEPTH];
    beat_t     wr_beat;
    beat_t     ram_rdata_q;

    wr_state_e state_q, state_d;
    logic [PW-1:0] wr_ptr_q, wr_ptr_d;
    logic [PW-1:0] commit_ptr_q, commit_ptr_d;
    logic [PW-1:0] rd_ptr_q, rd_ptr_d;
    logic          mem_we;
    logic          full;
    frame_ev_e     frame_ev;

    beat_t      ob0_q, ob0_d;
    beat_t      ob1_q, ob1_d;
    logic [1:0] ob_cnt_q, ob_cnt_d;
    logic       rd_vld_q;
    logic       rd_issue;
    logic       pop;
    logic [2:0] slots_used;

    assign wr_beat = '{last: s_axis_tlast, keep: s_axis_tkeep, data: s_axis_tdata};

    // Full uses the pre-edge rd_ptr; a same-cycle read issue is simply not credited yet.
    assign full = (wr_ptr_q[AW-1:0] + AW'(1)) == rd_ptr_q[AW-1:0];

    // IDLE and WRITE share rules: in IDLE wr_ptr equals commit_ptr, so a rewind is a no-op.
    always_comb begin
        // NOTE: every output of a combinational block gets a default first, so no path infers a latch.
        state_d      = state_q;
        wr_ptr_d     = wr_ptr_q;
        commit_ptr_d = commit_ptr_q;
        mem_we       = 1'b0;
        frame_ev     = EV_NONE;
        case (state_q)
            ST_IDLE, ST_WRITE: begin
                if (s_axis_tvalid) begin
                    if (full) begin
                        wr_ptr_d = commit_ptr_q;
                        if (s_axis_tlast) begin
                            frame_ev = EV_OVF;
                            state_d  = ST_IDLE;
                        end else begin
                            state_d  = ST_DROP;
                        end
                    end else if (s_axis_tlast && s_axis_tuser) begin
                        wr_ptr_d = commit_ptr_q;
                        frame_ev = EV_BAD;
                        state_d  = ST_IDLE;
                    end else begin
                        mem_we   = 1'b1;
                        wr_ptr_d = wr_ptr_q + PW'(1);
                        if (s_axis_tlast) begin
                            commit_ptr_d = wr_ptr_q + PW'(1);
                            frame_ev     = EV_OK;
                            state_d      = ST_IDLE;
                        end else begin
                            state_d      = ST_WRITE;
                        end
                    end
                end
            end
            ST_DROP: begin
                if (s_axis_tvalid && s_axis_tlast) begin
                    frame_ev = EV_OVF;
                    state_d  = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // Read side: issue while committed data exists and the output buffer will have a slot,
    // counting the word already in the RAM read stage and any beat leaving this cycle.
    assign pop        = (ob_cnt_q != 2'd0) && m_axis_tready;
    assign slots_used = 3'(ob_cnt_q) + 3'(rd_vld_q) - 3'(pop);
    assign rd_issue   = (commit_ptr_q != rd_ptr_q) && (slots_used < 3'd2);
    assign rd_ptr_d   = rd_ptr_q + PW'(rd_issue);

    always_comb begin
        ob0_d    = ob0_q;
        ob1_d    = ob1_q;
        ob_cnt_d = ob_cnt_q;
        case ({rd_vld_q, pop})
            2'b10: begin
                if (ob_cnt_q == 2'd0) ob0_d = ram_rdata_q;
                else                  ob1_d = ram_rdata_q;
                ob_cnt_d = ob_cnt_q + 2'd1;
            end
            2'b01: begin
                ob0_d    = ob1_q;
                ob_cnt_d = ob_cnt_q - 2'd1;
            end
            2'b11: begin
                if (ob_cnt_q == 2'd1) begin
                    ob0_d = ram_rdata_q;
                end else begin
                    ob0_d = ob1_q;
                    ob1_d = ram_rdata_q;
                end
            end
            default: ;
        endcase
    end

    // NOTE: the storage array has no reset; only pointers define which words are live.
    always_ff @(posedge clock) begin
        if (mem_we) mem[wr_ptr_q[AW-1:0]] <= wr_beat;
        if (rd_issue) ram_rdata_q <= mem[rd_ptr_q[AW-1:0]];
    end

    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            state_q      <= ST_IDLE;
            wr_ptr_q     <= '0;
            commit_ptr_q <= '0;
            rd_ptr_q     <= '0;
            rd_vld_q     <= 1'b0;
            ob0_q        <= '0;
            ob1_q        <= '0;
            ob_cnt_q     <= 2'd0;
        end else begin
            state_q      <= state_d;
            wr_ptr_q     <= wr_ptr_d;
            commit_ptr_q <= commit_ptr_d;
            rd_ptr_q     <= rd_ptr_d;
            rd_vld_q     <= rd_issue;
            ob0_q        <= ob0_d;
            ob1_q        <= ob1_d;
            ob_cnt_q     <= ob_cnt_d;
        end
    end

    assign m_axis_tvalid = (ob_cnt_q != 2'd0);
    assign m_axis_tdata  = ob0_q.data;
    assign m_axis_tkeep  = ob0_q.keep;
    assign m_axis_tlast  = ob0_q.last;
    assign m_axis_tuser  = 1'b0;

`ifdef ETH_RX_STATS_EN
    logic [15:0] ok_q, ok_d;
    logic [15:0] bad_q, bad_d;
    logic [15:0] ovf_q, ovf_d;

    always_comb begin
        ok_d  = ok_q;
        bad_d = bad_q;
        ovf_d = ovf_q;
        if (frame_ev == EV_OK  && ok_q  != 16'hFFFF) ok_d  = ok_q  + 16'd1;
        if (frame_ev == EV_BAD && bad_q != 16'hFFFF) bad_d = bad_q + 16'd1;
        if (frame_ev == EV_OVF && ovf_q != 16'hFFFF) ovf_d = ovf_q + 16'd1;
    end

    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            ok_q  <= 16'h0000;
            bad_q <= 16'h0000;
            ovf_q <= 16'h0000;
        end else begin
            ok_q  <= ok_d;
            bad_q <= bad_d;
            ovf_q <= ovf_d;
        end
    end

    assign frames_ok  = ok_q;
    assign frames_bad = bad_q;
    assign frames_ovf = ovf_q;
`else
    logic unused_frame_ev;
    assign unused_frame_ev = ^frame_ev;
    assign frames_ok  = 16'h0000;
    assign frames_bad = 16'h0000;
    assign frames_ovf = 16'h0000;
`endif

endmodule

// File: tb/tb_eth_rx_frame_buffer.sv
// Scoreboard bench for eth_rx_frame_buffer: a default-depth instance (unit 0) and a
// DEPTH_LOG2=4 instance (unit 1) for the overflow cases. Counter checks follow ETH_RX_STATS_EN.
module tb_eth_rx_frame_buffer;

    logic clock = 1'b0;
    logic resetn = 1'b0;
    always #5 clock = ~clock;

    logic [63:0] s0_tdata, s1_tdata;
    logic [7:0]  s0_tkeep, s1_tkeep;
    logic        s0_tlast, s1_tlast, s0_tuser, s1_tuser, s0_tvalid, s1_tvalid;
    logic [63:0] m0_tdata, m1_tdata;
    logic [7:0]  m0_tkeep, m1_tkeep;
    logic        m0_tlast, m1_tlast, m0_tuser, m1_tuser, m0_tvalid, m1_tvalid;
    logic        m0_tready, m1_tready;
    logic [15:0] ok0, bad0, ovf0, ok1, bad1, ovf1;

    logic rnd_mode = 1'b0;
    logic rdy_rnd  = 1'b1;
    logic rdy0_fix = 1'b1;
    logic rdy1_fix = 1'b1;
    assign m0_tready = rnd_mode ? rdy_rnd : rdy0_fix;
    assign m1_tready = rdy1_fix;

    eth_rx_frame_buffer dut0 (
        .clock(clock), .resetn(resetn),
        .s_axis_tdata(s0_tdata), .s_axis_tkeep(s0_tkeep), .s_axis_tlast(s0_tlast),
        .s_axis_tuser(s0_tuser), .s_axis_tvalid(s0_tvalid),
        .m_axis_tdata(m0_tdata), .m_axis_tkeep(m0_tkeep), .m_axis_tlast(m0_tlast),
        .m_axis_tuser(m0_tuser), .m_axis_tvalid(m0_tvalid), .m_axis_tready(m0_tready),
        .frames_ok(ok0), .frames_bad(bad0), .frames_ovf(ovf0)
    );

    eth_rx_frame_buffer #(.DEPTH_LOG2(4)) dut1 (
        .clock(clock), .resetn(resetn),
        .s_axis_tdata(s1_tdata), .s_axis_tkeep(s1_tkeep), .s_axis_tlast(s1_tlast),
        .s_axis_tuser(s1_tuser), .s_axis_tvalid(s1_tvalid),
        .m_axis_tdata(m1_tdata), .m_axis_tkeep(m1_tkeep), .m_axis_tlast(m1_tlast),
        .m_axis_tuser(m1_tuser), .m_axis_tvalid(m1_tvalid), .m_axis_tready(m1_tready),
        .frames_ok(ok1), .frames_bad(bad1), .frames_ovf(ovf1)
    );

    int checks = 0;
    int errors = 0;
    logic [72:0] exp_q0[$];
    logic [72:0] exp_q1[$];

    task automatic check(input string tag, input logic [72:0] act, input logic [72:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
        end
    endtask

    function automatic logic [72:0] cnt_exp(input int n);
`ifdef ETH_RX_STATS_EN
        return 73'(n);
`else
        return 73'(n - n);
`endif
    endfunction

    always @(posedge clock) begin
        #1;
        rdy_rnd = 1'($urandom_range(0, 1));
    end

    // Unit 0 monitor: scoreboard compare plus stability of a stalled beat.
    logic        stall0 = 1'b0;
    logic [72:0] held0, cur0, cur1;
    always @(negedge clock) begin
        cur0 = {m0_tlast, m0_tkeep, m0_tdata};
        if (!resetn) begin
            stall0 = 1'b0;
        end else begin
            if (stall0) begin
                check("hold_valid0", 73'(m0_tvalid), 73'(1));
                check("stable_beat0", cur0, held0);
            end
            if (m0_tvalid && m0_tready) begin
                if (exp_q0.size() == 0) check("unexpected_beat0", 73'(exp_q0.size()), 73'(1));
                else check("beat0", cur0, exp_q0.pop_front());
            end
            stall0 = m0_tvalid && !m0_tready;
            held0  = cur0;
        end
    end

    always @(negedge clock) begin
        cur1 = {m1_tlast, m1_tkeep, m1_tdata};
        if (resetn && m1_tvalid && m1_tready) begin
            if (exp_q1.size() == 0) check("unexpected_beat1", 73'(exp_q1.size()), 73'(1));
            else check("beat1", cur1, exp_q1.pop_front());
        end
    end

    task automatic idle_inputs();
        s0_tdata = '0; s0_tkeep = '0; s0_tlast = 0; s0_tuser = 0; s0_tvalid = 0;
        s1_tdata = '0; s1_tkeep = '0; s1_tlast = 0; s1_tuser = 0; s1_tvalid = 0;
    endtask

    task automatic do_reset();
        resetn = 1'b0;
        idle_inputs();
        repeat (2) @(posedge clock);
        @(negedge clock);
        resetn = 1'b1;
        @(posedge clock);
        #1;
    endtask

    task automatic send_beat(input int u, input logic [63:0] d, input logic [7:0] k,
                             input logic l, input logic usr);
        if (u == 0) begin
            s0_tdata = d; s0_tkeep = k; s0_tlast = l; s0_tuser = usr; s0_tvalid = 1'b1;
        end else begin
            s1_tdata = d; s1_tkeep = k; s1_tlast = l; s1_tuser = usr; s1_tvalid = 1'b1;
        end
        @(posedge clock);
        #1;
        if (u == 0) s0_tvalid = 1'b0;
        else        s1_tvalid = 1'b0;
    endtask

    // Good frames that are expected out are pushed to the scoreboard as they are driven.
    task automatic send_frame(input int u, input int len, input bit bad,
                              input logic [7:0] keep_last, input bit push);
        logic [63:0] d;
        logic [7:0]  k;
        logic        l;
        for (int i = 0; i < len; i++) begin
            d = {$urandom(), $urandom()};
            l = (i == len - 1);
            k = l ? keep_last : 8'hFF;
            if (push && u == 0) exp_q0.push_back({l, k, d});
            if (push && u == 1) exp_q1.push_back({l, k, d});
            send_beat(u, d, k, l, l && bad);
        end
    endtask

    task automatic wait_drain(input int u, input int budget);
        int n;
        n = 0;
        while (((u == 0) ? exp_q0.size() : exp_q1.size()) != 0 && n < budget) begin
            @(posedge clock);
            n++;
        end
        #1;
        check((u == 0) ? "drain0" : "drain1",
              73'((u == 0) ? exp_q0.size() : exp_q1.size()), 73'(0));
        repeat (5) @(posedge clock);
        #1;
    endtask

    initial begin
        int n_ok;
        int n_bad;
        int len;
        int guard;
        bit bad;

        idle_inputs();
        resetn = 1'b0;
        repeat (2) @(posedge clock);
        @(negedge clock);
        check("rst_tvalid0", 73'(m0_tvalid), 73'(0));
        check("rst_beat0", {m0_tlast, m0_tkeep, m0_tdata}, 73'(0));
        check("rst_tvalid1", 73'(m1_tvalid), 73'(0));
        check("rst_ok0", 73'(ok0), 73'(0));
        check("rst_ovf1", 73'(ovf1), 73'(0));
        resetn = 1'b1;
        @(posedge clock);
        #1;

        // Good frame latency: tvalid rises two edges after the tlast edge, then 8 back-to-back beats.
        rdy0_fix = 1'b1;
        send_frame(0, 8, 1'b0, 8'h0F, 1'b1);
        for (int c = 0; c <= 10; c++) begin
            @(negedge clock);
            check("latency_valid", 73'(m0_tvalid), 73'((c >= 2 && c <= 9) ? 1 : 0));
            if (c == 2) check("tuser_zero", 73'(m0_tuser), 73'(0));
        end
        check("lat_ok", 73'(ok0), cnt_exp(1));
        check("lat_queue", 73'(exp_q0.size()), 73'(0));
        @(posedge clock);
        #1;

        // Bad frame discard with space reclaimed.
        do_reset();
        send_frame(0, 5, 1'b1, 8'hFF, 1'b0);
        send_frame(0, 3, 1'b0, 8'h03, 1'b1);
        wait_drain(0, 100);
        check("bad_cnt", 73'(bad0), cnt_exp(1));
        check("bad_ok", 73'(ok0), cnt_exp(1));
        check("bad_wr_ptr", 73'(dut0.wr_ptr_q), 73'(3));
        check("bad_commit_ptr", 73'(dut0.commit_ptr_q), 73'(3));
        check("bad_rd_ptr", 73'(dut0.rd_ptr_q), 73'(3));

        // Overflow drop on the 15-word instance with the output stalled.
        do_reset();
        rdy1_fix = 1'b0;
        send_frame(1, 10, 1'b0, 8'hFF, 1'b1);
        send_frame(1, 10, 1'b0, 8'h7F, 1'b0);
        repeat (5) @(posedge clock);
        #1;
        check("ovf_cnt", 73'(ovf1), cnt_exp(1));
        check("ovf_ok", 73'(ok1), cnt_exp(1));
        check("ovf_wr_ptr", 73'(dut1.wr_ptr_q), 73'(10));
        rdy1_fix = 1'b1;
        wait_drain(1, 100);
        check("ovf_commit_ptr", 73'(dut1.commit_ptr_q), 73'(10));

        // Oversized frame into an empty buffer.
        do_reset();
        send_frame(1, 20, 1'b0, 8'hFF, 1'b0);
        repeat (10) @(posedge clock);
        #1;
        check("big_ovf", 73'(ovf1), cnt_exp(1));
        check("big_ok", 73'(ok1), cnt_exp(0));
        check("big_wr_ptr", 73'(dut1.wr_ptr_q), 73'(0));
        check("big_commit_ptr", 73'(dut1.commit_ptr_q), 73'(0));
        check("big_no_valid", 73'(m1_tvalid), 73'(0));

        // Random back-pressure over 200 back-to-back frames; the bench never sends a frame
        // that could overflow given the words it has not yet seen leave.
        do_reset();
        rnd_mode = 1'b1;
        n_ok  = 0;
        n_bad = 0;
        for (int f = 0; f < 200; f++) begin
            len   = $urandom_range(1, 64);
            bad   = ($urandom_range(0, 9) == 0);
            guard = 0;
            while (exp_q0.size() + len > 511 && guard < 2000) begin
                @(posedge clock);
                #1;
                guard++;
            end
            if (guard >= 2000) check("space_wait", 73'(exp_q0.size() + len), 73'(511));
            send_frame(0, len, bad, 8'($urandom_range(1, 255)), !bad);
            if (bad) n_bad++;
            else     n_ok++;
        end
        wait_drain(0, 40000);
        rnd_mode = 1'b0;
        check("rand_ok", 73'(ok0), cnt_exp(n_ok));
        check("rand_bad", 73'(bad0), cnt_exp(n_bad));
        check("rand_ovf", 73'(ovf0), cnt_exp(0));

        // Reset during beat 3 of a frame, then a 2-beat good frame.
        rdy0_fix = 1'b1;
        send_beat(0, 64'h1111, 8'hFF, 1'b0, 1'b0);
        send_beat(0, 64'h2222, 8'hFF, 1'b0, 1'b0);
        s0_tdata = 64'h3333; s0_tkeep = 8'hFF; s0_tlast = 1'b0; s0_tuser = 1'b0; s0_tvalid = 1'b1;
        #2;
        resetn = 1'b0;
        for (int c = 0; c < 3; c++) begin
            @(negedge clock);
            check("rst_hold_valid", 73'(m0_tvalid), 73'(0));
        end
        s0_tvalid = 1'b0;
        @(negedge clock);
        resetn = 1'b1;
        @(posedge clock);
        #1;
        check("mid_ok_zero", 73'(ok0), 73'(0));
        check("mid_bad_zero", 73'(bad0), 73'(0));
        check("mid_ovf_zero", 73'(ovf0), 73'(0));
        check("mid_wr_ptr", 73'(dut0.wr_ptr_q), 73'(0));
        send_frame(0, 2, 1'b0, 8'h01, 1'b1);
        wait_drain(0, 100);
        check("mid_ok", 73'(ok0), cnt_exp(1));

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
